atmos_light_est: RTL and testbench

//  Per-frame atmospheric-light (A) estimator; sits directly upstream of the saturation stage and drives its A_r/A_g/A_b inputs.

---
 rtl/dehaze_pkg.sv | 43 ++++
 rtl/min3_u8.sv | 18 +
 rtl/atmos_light_est.sv | 139 +++++++++++++
 tb/tb_atmos_light_est.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dehaze_pkg.sv
// Shared types and helpers for the dehaze pipeline.
//   PIX_W       : channel width
//   ale_state_e : atmospheric-light estimator FSM encoding
//   ale_pix_t   : dark channel plus RGB, carried through the estimator pipe
//   iir_clamp   : one channel of the A update (IIR step or direct load, then clamp)
package dehaze_pkg;

  localparam int PIX_W = 8;

  typedef enum logic [1:0] {
    ALE_IDLE   = 2'd0,
    ALE_ACCUM  = 2'd1,
    ALE_UPDATE = 2'd2
  } ale_state_e;

  // rgb[0]=r, rgb[1]=g, rgb[2]=b
  typedef struct packed {
    logic [PIX_W-1:0]        dark;
    logic [2:0][PIX_W-1:0]   rgb;
  } ale_pix_t;

  // first=1 loads cand directly; otherwise a + ((cand-a) >>> shift) with the
  // 9b signed difference so the shift floors toward -inf. Result clamped to
  // [a_min, 255] so the downstream inverse-A LUT never sees a small A.
  function automatic logic [PIX_W-1:0] iir_clamp(
    input logic [PIX_W-1:0] a,
    input logic [PIX_W-1:0] cand,
    input int               shift,
    input logic [PIX_W-1:0] a_min,
    input logic             first
  );
    logic signed [PIX_W:0]   d;
    logic signed [PIX_W:0]   step;
    logic signed [PIX_W+1:0] sum;
    d    = $signed({1'b0, cand}) - $signed({1'b0, a});
    step = d >>> shift;
    sum  = first ? $signed({2'b00, cand}) : ($signed({2'b00, a}) + step);
    if (sum < $signed({2'b00, a_min}))  return a_min;
    else if (sum > 10'sd255)           return 8'hFF;
    else                               return sum[PIX_W-1:0];
  endfunction

endpackage

// File: rtl/min3_u8.sv
// Combinational unsigned minimum of three channels (dark-channel primitive).
//   a, b, c : inputs
//   y       : min(a, b, c)
module min3_u8
  import dehaze_pkg::*;
(
  input  logic [PIX_W-1:0] a,
  input  logic [PIX_W-1:0] b,
  input  logic [PIX_W-1:0] c,
  output logic [PIX_W-1:0] y
);

  logic [PIX_W-1:0] ab;

  assign ab = (a < b) ? a : b;
  assign y  = (ab < c) ? ab : c;

endmodule

// File: rtl/atmos_light_est.sv
// Per-frame atmospheric-light estimator.
// Tracks the pixel with the largest dark channel in each frame, then at frame
// end folds that pixel into A with an IIR step and clamp. A is a registered
// level that only moves in the single cycle A_valid is high.
//   clk, rst           : clock, asynchronous active-high reset
//   in_r/g/b, in_valid : pixel stream, no backpressure
//   in_sof             : first pixel of a frame (qualified by in_valid)
//   A_r/g/b            : current atmospheric light
//   A_valid            : pulse in the cycle A changes
//   a_locked           : set after the first committed frame
//   frame_err          : pulse when a short frame is dropped
module atmos_light_est
  import dehaze_pkg::*;
#(
  parameter int               IMG_W       = 640,
  parameter int               IMG_H       = 480,
  parameter int               ALPHA_SHIFT = 3,
  parameter logic [PIX_W-1:0] A_MIN       = 8'd64,
  parameter logic [PIX_W-1:0] A_INIT      = 8'd200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PIX_W-1:0] in_r,
  input  logic [PIX_W-1:0] in_g,
  input  logic [PIX_W-1:0] in_b,
  input  logic             in_valid,
  input  logic             in_sof,
  output logic [PIX_W-1:0] A_r,
  output logic [PIX_W-1:0] A_g,
  output logic [PIX_W-1:0] A_b,
  output logic             A_valid,
  output logic             a_locked,
  output logic             frame_err
);

  localparam int          N   = IMG_W * IMG_H;
  localparam int          CW  = $clog2(N + 1);
  localparam logic [CW-1:0] N_C = CW'(N);

  // ---- S1: dark channel ----
  logic [PIX_W-1:0] dark_in;
  ale_pix_t         s1_pix;
  logic             s1_vld, s1_sof;

  min3_u8 u_min3 (.a(in_r), .b(in_g), .c(in_b), .y(dark_in));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld <= 1'b0;
      s1_sof <= 1'b0;
      s1_pix <= '0;
    end else begin
      s1_vld <= in_valid;
      s1_sof <= in_valid & in_sof;
      s1_pix <= '{dark: dark_in, rgb: {in_b, in_g, in_r}};
    end
  end

  // ---- S2: accumulator ----
  ale_state_e            state, state_nxt;
  ale_pix_t              best, new_best;
  logic [CW-1:0]         cnt, new_cnt;
  logic [2:0][PIX_W-1:0] cand;
  logic                  take, done, abort;

  // sof always starts a frame; plain pixels count only inside a frame, so
  // stragglers after pixel N (or before any sof) fall through.
  assign take     = s1_vld && (s1_sof || state == ALE_ACCUM);
  assign new_best = (s1_sof || (s1_pix.dark > best.dark)) ? s1_pix : best;
  assign new_cnt  = s1_sof ? CW'(1) : cnt + CW'(1);
  assign done     = take && (new_cnt == N_C);
  assign abort    = s1_vld && s1_sof && (state == ALE_ACCUM) && (cnt != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ALE_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ALE_IDLE:   if (done) state_nxt = ALE_UPDATE;
                  else if (take) state_nxt = ALE_ACCUM;
      ALE_ACCUM:  if (done) state_nxt = ALE_UPDATE;
      // a sof landing during the commit cycle keeps the new frame running
      ALE_UPDATE: if (done) state_nxt = ALE_UPDATE;
                  else if (take) state_nxt = ALE_ACCUM;
                  else state_nxt = ALE_IDLE;
      default:    state_nxt = ALE_IDLE;
    endcase
  end

  // Candidate is captured on completion so best/cnt are free for a
  // back-to-back sof in the following cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      best      <= '0;
      cnt       <= '0;
      cand      <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= abort;
      if (done) begin
        cand <= new_best.rgb;
        best <= '0;
        cnt  <= '0;
      end else if (take) begin
        best <= new_best;
        cnt  <= new_cnt;
      end
    end
  end

  // ---- A update ----
  logic [2:0][PIX_W-1:0] a_q, a_nxt;

  for (genvar i = 0; i < 3; i++) begin : g_ch
    assign a_nxt[i] = iir_clamp(a_q[i], cand[i], ALPHA_SHIFT, A_MIN, !a_locked);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= {3{A_INIT}};
      a_locked <= 1'b0;
      A_valid  <= 1'b0;
    end else begin
      A_valid <= (state == ALE_UPDATE);
      if (state == ALE_UPDATE) begin
        a_q      <= a_nxt;
        a_locked <= 1'b1;
      end
    end
  end

  assign A_r = a_q[0];
  assign A_g = a_q[1];
  assign A_b = a_q[2];

endmodule

// File: tb/tb_atmos_light_est.sv
module tb_atmos_light_est;

  localparam int N     = 8;
  localparam int AMIN  = 64;
  localparam int AINIT = 200;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_r, in_g, in_b;
  logic       in_valid, in_sof;
  logic [7:0] A_r, A_g, A_b;
  logic       A_valid, a_locked, frame_err;

  always #5 clk = ~clk;

  atmos_light_est #(
    .IMG_W(4), .IMG_H(2), .ALPHA_SHIFT(3), .A_MIN(8'd64), .A_INIT(8'd200)
  ) dut (
    .clk(clk), .rst(rst),
    .in_r(in_r), .in_g(in_g), .in_b(in_b),
    .in_valid(in_valid), .in_sof(in_sof),
    .A_r(A_r), .A_g(A_g), .A_b(A_b),
    .A_valid(A_valid), .a_locked(a_locked), .frame_err(frame_err)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_run = 0, n_fail = 0;

  task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d exp %0d", tag, act, exp);
    end
  endtask

  // ---- scoreboard ----
  typedef struct { int cyc; int r; int g; int b; } exp_t;
  exp_t q[$];

  int  mon_a[3] = '{AINIT, AINIT, AINIT};
  bit  mon_locked = 1'b0;
  int  seen_err = 0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      mon_a      = '{AINIT, AINIT, AINIT};
      mon_locked = 1'b0;
    end else begin
      if (frame_err) seen_err++;
      if (A_valid) begin
        if (q.size() == 0) chk("spurious_A_valid", 1, 0);
        else begin
          e = q.pop_front();
          chk("A_latency", cyc, e.cyc);
          mon_a      = '{e.r, e.g, e.b};
          mon_locked = 1'b1;
        end
      end
      chk("A_r", A_r, mon_a[0]);
      chk("A_g", A_g, mon_a[1]);
      chk("A_b", A_b, mon_a[2]);
      chk("a_locked", a_locked, mon_locked);
    end
  end

  // ---- reference model ----
  int  m_a[3];
  bit  m_locked;
  int  exp_err = 0;
  int  fr[N][3];

  function automatic int clampa(int v);
    if (v < AMIN) return AMIN;
    if (v > 255)  return 255;
    return v;
  endfunction

  function automatic int iir(int a, int c);
    int d, s;
    d = c - a;
    s = (d >= 0) ? d / 8 : -((-d + 7) / 8);  // floor(d/8)
    return clampa(a + s);
  endfunction

  function automatic int dk(int k);
    int m;
    m = fr[k][0];
    if (fr[k][1] < m) m = fr[k][1];
    if (fr[k][2] < m) m = fr[k][2];
    return m;
  endfunction

  task automatic fill_bg();
    for (int k = 0; k < N; k++)
      for (int c = 0; c < 3; c++) fr[k][c] = $urandom_range(0, 100);
  endtask

  task automatic set_px(int k, int r, int g, int b);
    fr[k][0] = r; fr[k][1] = g; fr[k][2] = b;
  endtask

  task automatic drive(int r, int g, int b, bit sof);
    in_r = r[7:0]; in_g = g[7:0]; in_b = b[7:0];
    in_valid = 1'b1; in_sof = sof;
    @(posedge clk); #1;
    in_valid = 1'b0; in_sof = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Drives the first n pixels of fr; a complete frame schedules a commit.
  task automatic send(int n);
    int bi, c0;
    bi = 0;
    c0 = 0;
    for (int k = 0; k < n; k++) begin
      if (k > 0 && dk(k) > dk(bi)) bi = k;
      c0 = cyc;
      drive(fr[k][0], fr[k][1], fr[k][2], k == 0);
    end
    if (n == N) begin
      for (int c = 0; c < 3; c++)
        m_a[c] = m_locked ? iir(m_a[c], fr[bi][c]) : clampa(fr[bi][c]);
      m_locked = 1'b1;
      q.push_back('{c0 + 3, m_a[0], m_a[1], m_a[2]});
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 12 && q.size() != 0; i++) idle(1);
    chk("drain_timeout", q.size(), 0);
    idle(2);
  endtask

  task automatic model_reset();
    m_a = '{AINIT, AINIT, AINIT};
    m_locked = 1'b0;
    q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    idle(3);
    rst = 1'b0;
    idle(1);
  endtask

  task automatic chk_a(string tag, int r, int g, int b);
    chk({tag, "_r"}, A_r, r);
    chk({tag, "_g"}, A_g, g);
    chk({tag, "_b"}, A_b, b);
  endtask

  initial begin
    rst = 1'b1; in_r = '0; in_g = '0; in_b = '0; in_valid = 1'b0; in_sof = 1'b0;
    model_reset();

    // 1: reset state held with no input
    #12;
    chk_a("rst_state", AINIT, AINIT, AINIT);
    chk("rst_A_valid", A_valid, 0);
    chk("rst_frame_err", frame_err, 0);
    do_reset();
    idle(10);
    chk_a("idle", AINIT, AINIT, AINIT);
    chk("idle_locked", a_locked, 0);

    // stray pixels without sof are ignored in IDLE
    drive(255, 255, 255, 1'b0);
    drive(255, 255, 255, 1'b0);
    idle(4);

    // 2: first commit loads the candidate directly
    fill_bg(); set_px(5, 250, 240, 230);
    send(N); drain();
    chk_a("frame1", 250, 240, 230);
    chk("frame1_locked", a_locked, 1);

    // 3: IIR step with negative differences
    fill_bg(); set_px(2, 90, 90, 90);
    send(N); drain();
    chk_a("frame2", 230, 221, 212);

    // 4: black frames pull A down to the clamp
    for (int f = 0; f < 20; f++) begin
      fill_bg();
      for (int k = 0; k < N; k++) set_px(k, 0, 0, 0);
      send(N); idle(1);
    end
    drain();
    chk_a("settle", AMIN, AMIN, AMIN);

    // 5: tie keeps the earlier pixel
    do_reset();
    fill_bg(); set_px(2, 200, 255, 255); set_px(6, 255, 255, 200);
    send(N); drain();
    chk_a("tie", 200, 255, 255);

    // 6a: short frame aborted, following frame commits
    fill_bg(); send(3);
    exp_err++;
    fill_bg(); set_px(7, 180, 170, 160);
    send(N); drain();

    // 6b: back-to-back frames, then extra pixels past N
    fill_bg(); set_px(0, 240, 250, 245);
    send(N);
    fill_bg(); set_px(4, 120, 130, 140);
    send(N);
    drive(250, 250, 250, 1'b0);
    drive(250, 250, 250, 1'b0);
    drain();
    fill_bg(); set_px(3, 150, 160, 170);
    send(N); drain();
    chk("frame_err_count", seen_err, exp_err);

    // 6c: reset mid-frame returns to the reset state at once
    fill_bg(); send(3);
    rst = 1'b1;
    #2;
    chk_a("rst_mid", AINIT, AINIT, AINIT);
    chk("rst_mid_locked", a_locked, 0);
    model_reset();
    idle(3);
    rst = 1'b0;
    idle(1);
    fill_bg(); set_px(1, 100, 110, 120);
    send(N); drain();
    chk_a("post_rst", 100, 110, 120);
    chk("post_rst_locked", a_locked, 1);
    chk("frame_err_final", seen_err, exp_err);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
